// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60 timing, count widths, 3/3/2 colour constants.
// Latency: n/a (package). Backpressure: n/a.
// Imported by the timing generator and by the pixel renderer.
package vga_pkg;

  // 640x480@60 timing, in pixels (horizontal) and lines (vertical)
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;  // 800

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;  // 525

  localparam bit VGA_SYNC_ACTIVE = 1'b0;  // sync pulses are active-low
  localparam int VGA_CLK_DIV     = 4;     // 100 MHz system clock -> 25 MHz pixel rate

  // Coordinate counters fit any total below 2048; the divider covers 1..16.
  localparam int CNT_W = 11;
  localparam int DIV_W = 4;

  // 8-bit colour, packed [B1 B2 G1 G2 G3 R1 R2 R3]
  localparam int R_LSB = 0;
  localparam int R_W   = 3;
  localparam int G_LSB = 3;
  localparam int G_W   = 3;
  localparam int B_LSB = 6;
  localparam int B_W   = 2;

  localparam logic [7:0] COLOR_BLACK   = 8'h00;
  localparam logic [7:0] COLOR_RED     = 8'h07;
  localparam logic [7:0] COLOR_GREEN   = 8'h38;
  localparam logic [7:0] COLOR_BLUE    = 8'hC0;
  localparam logic [7:0] COLOR_YELLOW  = 8'h3F;
  localparam logic [7:0] COLOR_CYAN    = 8'hF8;
  localparam logic [7:0] COLOR_MAGENTA = 8'hC7;
  localparam logic [7:0] COLOR_WHITE   = 8'hFF;

  typedef struct packed {
    logic [B_W-1:0] b;
    logic [G_W-1:0] g;
    logic [R_W-1:0] r;
  } rgb332_t;

  function automatic rgb332_t unpack_rgb(input logic [7:0] c);
    rgb332_t p;
    p.r = c[R_LSB +: R_W];
    p.g = c[G_LSB +: G_W];
    p.b = c[B_LSB +: B_W];
    return p;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate enable: divides the system clock by CLK_DIV into a one-clk pix_tick pulse.
// Latency: first pix_tick on clock edge CLK_DIV after reset release. Backpressure: none, free-running.
// Ports: clk_i system clock, rst_i async active-high reset, pix_tick_o registered pixel enable.
module vga_pix_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV  // legal 1..16
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic pix_tick_o
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_tick_q, pix_tick_d;

  // The tick is raised by the edge that wraps the divider, so it is high
  // during the last clk of each pixel period. With CLK_DIV=1 the divider
  // sits at its last value and the tick stays high.
  always_comb begin
    div_cnt_d  = div_cnt_q + DIV_W'(1);
    pix_tick_d = 1'b0;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d  = '0;
      pix_tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q  <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  assign pix_tick_o = pix_tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: x/y scan counters, frame tick, sync generation and blanked 3/3/2 colour pins.
// Latency: connector outputs lag the counters by one pixel period. Backpressure: none, free-running.
// Ports: clk, reset (async, active-high), rgb_in renderer colour; x, y, pix_tick, frame_tick,
//        video_on toward the renderer; hsync, vsync, vga_r/g/b toward the connector.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_VISIBLE   = VGA_H_VISIBLE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_VISIBLE   = VGA_V_VISIBLE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter bit SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rgb_in,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             pix_tick,
  output logic             frame_tick,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic [R_W-1:0]   vga_r,
  output logic [G_W-1:0]   vga_g,
  output logic [B_W-1:0]   vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic pix_tick_w;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk_i      (clk),
    .rst_i      (reset),
    .pix_tick_o (pix_tick_w)
  );

  // ---------------- scan counters ----------------
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             frame_tick_q, frame_tick_d;

  // frame_tick is produced by the same edge that wraps both counters, so it
  // is high exactly during the first clk in which (x,y) reads (0,0).
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    frame_tick_d = 1'b0;
    if (pix_tick_w) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d          = '0;
          frame_tick_d = 1'b1;
        end else begin
          y_d = y_q + CNT_W'(1);
        end
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // ---------------- pixel-state decode (current counters) ----------------
  logic    video_on_w, hs_raw_w, vs_raw_w;
  rgb332_t pix_w;

  always_comb begin
    video_on_w = (x_q < X_VIS) && (y_q < Y_VIS);
    hs_raw_w   = (x_q >= HS_START) && (x_q < HS_END);
    vs_raw_w   = (y_q >= VS_START) && (y_q < VS_END);
    pix_w      = unpack_rgb(rgb_in);
  end

  // ---------------- connector output stage ----------------
  // Captures the pixel being left on each pixel boundary, so sync and colour
  // for one pixel always reach the pins together.
  logic           hsync_q, hsync_d, vsync_q, vsync_d;
  logic [R_W-1:0] vga_r_q, vga_r_d;
  logic [G_W-1:0] vga_g_q, vga_g_d;
  logic [B_W-1:0] vga_b_q, vga_b_d;

  always_comb begin
    hsync_d = hs_raw_w ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = vs_raw_w ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vga_r_d = '0;
    vga_g_d = '0;
    vga_b_d = '0;
    if (video_on_w) begin
      vga_r_d = pix_w.r;
      vga_g_d = pix_w.g;
      vga_b_d = pix_w.b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      vga_r_q <= '0;
      vga_g_q <= '0;
      vga_b_q <= '0;
    end else if (pix_tick_w) begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vga_r_q <= vga_r_d;
      vga_g_q <= vga_g_d;
      vga_b_q <= vga_b_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign pix_tick   = pix_tick_w;
  assign frame_tick = frame_tick_q;
  assign video_on   = video_on_w;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign vga_r      = vga_r_q;
  assign vga_g      = vga_g_q;
  assign vga_b      = vga_b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (15x8 totals) so whole frames stay short.
// Geometry: H 8 visible / 2 fp / 3 sync / 2 bp; V 4 visible / 1 fp / 2 sync / 1 bp.
// Hand-derived: hsync low for captured x=10..12, vsync low for captured y=5..6.
module tb_vga_timing_gen;

  localparam int CLK_DIV   = 4;
  localparam int HT        = 15;
  localparam int VT        = 8;
  localparam int FRAME_PIX = 120;            // HT*VT
  localparam int N_PIX     = 3 * FRAME_PIX;  // frame 0 white, frame 1 single dot, frame 2 varied

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] rgb_in = 8'h00;

  logic [10:0] x_a, y_a, x_b, y_b;
  logic        pix_tick_a, frame_tick_a, video_on_a, hsync_a, vsync_a;
  logic        pix_tick_b, frame_tick_b, video_on_b, hsync_b, vsync_b;
  logic [2:0]  r_a, g_a, r_b, g_b;
  logic [1:0]  b_a, b_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0)
  ) u_dut (
    .clk(clk), .reset(reset), .rgb_in(rgb_in), .x(x_a), .y(y_a),
    .pix_tick(pix_tick_a), .frame_tick(frame_tick_a), .video_on(video_on_a),
    .hsync(hsync_a), .vsync(vsync_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0)
  ) u_dut_div1 (
    .clk(clk), .reset(reset), .rgb_in(8'h00), .x(x_b), .y(y_b),
    .pix_tick(pix_tick_b), .frame_tick(frame_tick_b), .video_on(video_on_b),
    .hsync(hsync_b), .vsync(vsync_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- expected-value generation ----------------
  typedef struct {
    int x, y, ft, von, hs, vs, r, g, b;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [7:0] rgb_for(input int n);
    int f  = n / FRAME_PIX;
    int p  = n % FRAME_PIX;
    int xn = p % HT;
    int yn = p / HT;
    if (f == 0) return 8'hFF;
    if (f == 1) return (xn == 5 && yn == 0) ? 8'b0100_1000 : 8'h00;
    return 8'((n * 37 + 11) & 255);
  endfunction

  // Expected connector/counter state just after pixel n has been captured.
  function automatic exp_t exp_for(input int n, input logic [7:0] c);
    exp_t e;
    int p  = n % FRAME_PIX;
    int q  = (n + 1) % FRAME_PIX;
    int xn = p % HT;
    int yn = p / HT;
    bit vis = (xn < 8) && (yn < 4);
    e.x   = q % HT;
    e.y   = q / HT;
    e.ft  = (q == 0) ? 1 : 0;
    e.von = (e.x < 8 && e.y < 4) ? 1 : 0;
    e.hs  = (xn >= 10 && xn <= 12) ? 0 : 1;
    e.vs  = (yn >= 5 && yn <= 6) ? 0 : 1;
    e.r   = vis ? int'(c[2:0]) : 0;
    e.g   = vis ? int'(c[5:3]) : 0;
    e.b   = vis ? int'(c[7:6]) : 0;
    return e;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic tick_seen = 1'b0;   // high in the clk after a pixel-boundary edge
  bit   mon_en    = 1'b0;
  bit   en_b      = 1'b0;
  exp_t mon_e;

  always @(posedge clk) tick_seen <= pix_tick_a;

  always @(negedge clk) begin
    if (mon_en) begin
      if (tick_seen) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: output with no expected entry (t=%0t)", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("x",          int'(x_a),          mon_e.x);
          check("y",          int'(y_a),          mon_e.y);
          check("frame_tick", int'(frame_tick_a), mon_e.ft);
          check("video_on",   int'(video_on_a),   mon_e.von);
          check("hsync",      int'(hsync_a),      mon_e.hs);
          check("vsync",      int'(vsync_a),      mon_e.vs);
          check("vga_r",      int'(r_a),          mon_e.r);
          check("vga_g",      int'(g_a),          mon_e.g);
          check("vga_b",      int'(b_a),          mon_e.b);
        end
      end else begin
        check("frame_tick_idle", int'(frame_tick_a), 0);
      end
    end
  end

  // ---------------- interval trackers ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int a_prev_x, a_last_wrap, a_last_ft, a_hs_run, a_vs_run, a_ft_cnt;
  always @(negedge clk) begin
    if (!mon_en) begin
      a_prev_x <= 0; a_last_wrap <= -1; a_last_ft <= -1;
      a_hs_run <= -1; a_vs_run <= -1; a_ft_cnt <= 0;
    end else begin
      if (x_a == 11'd0 && a_prev_x != 0) begin
        if (a_last_wrap >= 0) check("line_clks", cyc - a_last_wrap, HT * CLK_DIV);
        a_last_wrap <= cyc;
      end
      a_prev_x <= int'(x_a);
      if (frame_tick_a) begin
        if (a_last_ft >= 0) check("frame_clks", cyc - a_last_ft, FRAME_PIX * CLK_DIV);
        a_last_ft <= cyc;
        a_ft_cnt  <= a_ft_cnt + 1;
      end
      if (!hsync_a) begin
        if (a_hs_run >= 0) a_hs_run <= a_hs_run + 1;
      end else begin
        if (a_hs_run > 0) check("hsync_low_clks", a_hs_run, 3 * CLK_DIV);
        a_hs_run <= 0;
      end
      if (!vsync_a) begin
        if (a_vs_run >= 0) a_vs_run <= a_vs_run + 1;
      end else begin
        if (a_vs_run > 0) check("vsync_low_clks", a_vs_run, 2 * HT * CLK_DIV);
        a_vs_run <= 0;
      end
    end
  end

  int b_prev_x, b_last_wrap, b_last_ft, b_hs_run, b_vs_run;
  always @(negedge clk) begin
    if (!en_b) begin
      b_prev_x <= 0; b_last_wrap <= -1; b_last_ft <= -1;
      b_hs_run <= -1; b_vs_run <= -1;
    end else begin
      check("div1_pix_tick", int'(pix_tick_b), 1);
      if (x_b == 11'd0 && b_prev_x != 0) begin
        if (b_last_wrap >= 0) check("div1_line_clks", cyc - b_last_wrap, HT);
        b_last_wrap <= cyc;
      end
      b_prev_x <= int'(x_b);
      if (frame_tick_b) begin
        check("div1_ft_xy", int'(x_b) + int'(y_b), 0);
        if (b_last_ft >= 0) check("div1_frame_clks", cyc - b_last_ft, FRAME_PIX);
        b_last_ft <= cyc;
      end
      if (!hsync_b) begin
        if (b_hs_run >= 0) b_hs_run <= b_hs_run + 1;
      end else begin
        if (b_hs_run > 0) check("div1_hsync_low_clks", b_hs_run, 3);
        b_hs_run <= 0;
      end
      if (!vsync_b) begin
        if (b_vs_run >= 0) b_vs_run <= b_vs_run + 1;
      end else begin
        if (b_vs_run > 0) check("div1_vsync_low_clks", b_vs_run, 2 * HT);
        b_vs_run <= 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_boundary(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4 * CLK_DIV; k++) begin
      @(negedge clk);
      if (tick_seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int n_edges;
    logic [7:0] c;

    // Reset mid-line: asynchronous clear while the raster is running.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    rgb_in = 8'hFF;
    for (int k = 0; k < 200 && x_a != 11'd6; k++) @(negedge clk);
    check("pre_reset_x", int'(x_a), 6);
    check("pre_reset_r", int'(r_a), 7);
    #2 reset = 1'b1;
    #1;
    check("rst_x",          int'(x_a),          0);
    check("rst_y",          int'(y_a),          0);
    check("rst_hsync",      int'(hsync_a),      1);
    check("rst_vsync",      int'(vsync_a),      1);
    check("rst_vga_r",      int'(r_a),          0);
    check("rst_vga_g",      int'(g_a),          0);
    check("rst_vga_b",      int'(b_a),          0);
    check("rst_frame_tick", int'(frame_tick_a), 0);
    check("rst_pix_tick",   int'(pix_tick_a),   0);
    check("rst_div1_x",     int'(x_b),          0);

    // First pixel tick after release lands on edge CLK_DIV.
    @(negedge clk);
    reset   = 1'b0;
    n_edges = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      n_edges = k + 1;
      if (pix_tick_a) break;
    end
    check("first_tick_edge", n_edges, CLK_DIV);

    // Scoreboarded run: three full frames from a fresh reset.
    @(negedge clk);
    reset  = 1'b1;
    rgb_in = 8'h00;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    c      = rgb_for(0);
    rgb_in = c;
    sb_q.push_back(exp_for(0, c));
    mon_en = 1'b1;
    for (int n = 1; n < N_PIX; n++) begin
      wait_boundary(ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL pixel_boundary_timeout: no boundary before pixel %0d", n);
        break;
      end
      if (n == 1) en_b = 1'b1;
      c      = rgb_for(n);
      rgb_in = c;
      sb_q.push_back(exp_for(n, c));
    end
    wait_boundary(ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: last pixel boundary missing");
    end
    @(posedge clk);
    check("sb_drained",  sb_q.size(), 0);
    check("frame_ticks", a_ft_cnt,    3);
    mon_en = 1'b0;
    en_b   = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
